// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access engine for the RV32I core: one load/store per start,
// valid/ready memory port, lane-aligned stores and sign/zero-extended loads.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   // state  | meaning
   // IDLE   | waiting for start; request latches captured on start
   // REQ    | mem_req asserted, waiting for mem_ready or timeout
   // DONE   | one-cycle success pulse
   // ERR    | one-cycle error pulse (illegal request or timeout)
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          f3_bad, misaligned;
   logic [3:0]    be_lat;
   logic [31:0]   wdata_lanes;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_ext;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
      end
   end

   // Legality is judged on the live inputs so an illegal request never reaches REQ.
   always_comb begin
      if (we) f3_bad = (funct3 > 3'b010);
      else    f3_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   end

   always_comb begin
      case (funct3_q[1:0])
         2'b00:   be_lat = 4'b0001 << addr_q[1:0];
         2'b01:   be_lat = 4'b0011 << {addr_q[1], 1'b0};
         default: be_lat = 4'b1111;
      endcase
      case (funct3_q[1:0])
         2'b00:   wdata_lanes = {4{wdata_q[7:0]}};
         2'b01:   wdata_lanes = {2{wdata_q[15:0]}};
         default: wdata_lanes = wdata_q;
      endcase
   end

   always_comb begin
      case (addr_q[1:0])
         2'b00:   ld_byte = mem_rdata[7:0];
         2'b01:   ld_byte = mem_rdata[15:8];
         2'b10:   ld_byte = mem_rdata[23:16];
         default: ld_byte = mem_rdata[31:24];
      endcase
      ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'h0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'h0, ld_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               we_d     = we;
               funct3_d = funct3;
               addr_d   = addr;
               wdata_d  = wdata;
               cnt_d    = '0;
               state_d  = (f3_bad || misaligned) ? S_ERR : S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ready) begin
               if (!we_q) rdata_d = ld_ext;
               state_d = S_DONE;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Memory-side outputs are forced to zero outside REQ so the bus is quiet when idle.
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE) || (state_q == S_ERR);
      err       = (state_q == S_ERR);
      rdata     = rdata_q;
      mem_req   = (state_q == S_REQ);
      mem_we    = mem_req & we_q;
      mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
      mem_be    = mem_req ? be_lat : 4'h0;
      mem_wdata = (mem_req && we_q) ? wdata_lanes : 32'h0;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit plus hand-written multi-cycle sequences.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, start2 = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic        mem_ready = 1'b0, mem_ready2 = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   logic        busy, done, err, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        busy2, done2, err2, mem_req2, mem_we2;
   logic [31:0] rdata2, mem_addr2, mem_wdata2;
   logic [3:0]  mem_be2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .rst(rst), .start(start), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata));

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .rst(rst), .start(start2), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
      .busy(busy2), .done(done2), .err(err2), .rdata(rdata2), .mem_req(mem_req2), .mem_we(mem_we2),
      .mem_addr(mem_addr2), .mem_be(mem_be2), .mem_wdata(mem_wdata2),
      .mem_ready(mem_ready2), .mem_rdata(mem_rdata));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrd;
      logic        bad;
      logic [3:0]  be;
      logic [31:0] mwd;
      logic [31:0] rd;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs[NV];
   logic [31:0] exp_rd;
   int reqc, donec, cyc;
   logic [31:0] a0, be0;

   initial begin
      vecs[0]  = '{"lb_b3",    1'b0, 3'b000, 32'h203, 32'h0,        32'h80FF1234, 1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
      vecs[1]  = '{"lbu_b3",   1'b0, 3'b100, 32'h203, 32'h0,        32'h80FF1234, 1'b0, 4'b1000, 32'h0,        32'h00000080};
      vecs[2]  = '{"sh_hi",    1'b1, 3'b001, 32'h102, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
      vecs[3]  = '{"lw_mis",   1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[4]  = '{"lh_hi",    1'b0, 3'b001, 32'h006, 32'h0,        32'h80017FFF, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001};
      vecs[5]  = '{"lhu_lo",   1'b0, 3'b101, 32'h004, 32'h0,        32'h1234F00D, 1'b0, 4'b0011, 32'h0,        32'h0000F00D};
      vecs[6]  = '{"sb_b1",    1'b1, 3'b000, 32'h011, 32'h000000A5, 32'h0,        1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0};
      vecs[7]  = '{"sw",       1'b1, 3'b010, 32'h020, 32'hCAFEBABE, 32'h0,        1'b0, 4'b1111, 32'hCAFEBABE, 32'h0};
      vecs[8]  = '{"ld_f3_011",1'b0, 3'b011, 32'h000, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[9]  = '{"st_f3_100",1'b1, 3'b100, 32'h000, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[10] = '{"sh_mis",   1'b1, 3'b001, 32'h003, 32'h1234,     32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[11] = '{"lb_b1",    1'b0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 1'b0, 4'b0010, 32'h0,        32'h0000007F};
      vecs[12] = '{"lw",       1'b0, 3'b010, 32'h044, 32'h0,        32'h12345678, 1'b0, 4'b1111, 32'h0,        32'h12345678};

      #12;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_memreq", {31'h0, mem_req}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_memaddr", mem_addr, 32'h0);
      chk("rst_membe", {28'h0, mem_be}, 32'h0);
      @(negedge clk) rst = 1'b1;
      exp_rd = 32'h0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         we = vecs[i].we; funct3 = vecs[i].f3; addr = vecs[i].addr; wdata = vecs[i].wdata;
         mem_rdata = vecs[i].mrd; start = 1'b1;
         @(negedge clk) start = 1'b0;
         chk({vecs[i].name, "_busy"}, {31'h0, busy}, 32'h1);
         if (vecs[i].bad) begin
            chk({vecs[i].name, "_req"}, {31'h0, mem_req}, 32'h0);
            chk({vecs[i].name, "_done"}, {31'h0, done}, 32'h1);
            chk({vecs[i].name, "_err"}, {31'h0, err}, 32'h1);
            chk({vecs[i].name, "_rdata"}, rdata, exp_rd);
         end else begin
            chk({vecs[i].name, "_req"}, {31'h0, mem_req}, 32'h1);
            chk({vecs[i].name, "_we"}, {31'h0, mem_we}, {31'h0, vecs[i].we});
            chk({vecs[i].name, "_addr"}, mem_addr, {vecs[i].addr[31:2], 2'b00});
            chk({vecs[i].name, "_be"}, {28'h0, mem_be}, {28'h0, vecs[i].be});
            if (vecs[i].we) chk({vecs[i].name, "_wdata"}, mem_wdata, vecs[i].mwd);
            chk({vecs[i].name, "_done0"}, {31'h0, done}, 32'h0);
            mem_ready = 1'b1;
            @(negedge clk) mem_ready = 1'b0;
            if (!vecs[i].we) exp_rd = vecs[i].rd;
            chk({vecs[i].name, "_done"}, {31'h0, done}, 32'h1);
            chk({vecs[i].name, "_err"}, {31'h0, err}, 32'h0);
            chk({vecs[i].name, "_rdata"}, rdata, exp_rd);
         end
         @(negedge clk);
         chk({vecs[i].name, "_idle"}, {31'h0, busy}, 32'h0);
      end

      // LH addr 0x8, ready on the sixth request cycle
      we = 1'b0; funct3 = 3'b001; addr = 32'h8; mem_rdata = 32'h00008123; start = 1'b1;
      @(negedge clk) start = 1'b0;
      reqc = 0;
      for (int k = 0; k < 6; k++) begin
         if (k == 5) mem_ready = 1'b1;
         if (mem_req) reqc++;
         chk("lh_wait_addr", mem_addr, 32'h8);
         chk("lh_wait_be", {28'h0, mem_be}, 32'h3);
         chk("lh_wait_done", {31'h0, done}, 32'h0);
         @(negedge clk);
      end
      mem_ready = 1'b0;
      chk("lh_wait_reqcycles", reqc, 6);
      chk("lh_wait_done1", {31'h0, done & ~err}, 32'h1);
      exp_rd = 32'hFFFF8123;
      chk("lh_wait_rdata", rdata, exp_rd);
      @(negedge clk);

      // Timeout instance: no ready ever
      start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      reqc = 0; cyc = 0;
      while (!done2 && cyc < 20) begin
         if (mem_req2) reqc++;
         cyc++;
         @(negedge clk);
      end
      chk("to_reqcycles", reqc, 4);
      chk("to_done", {31'h0, done2}, 32'h1);
      chk("to_err", {31'h0, err2}, 32'h1);
      chk("to_rdata", rdata2, 32'h0);
      @(negedge clk);
      chk("to_idle", {31'h0, busy2}, 32'h0);

      // Reset mid-REQ
      we = 1'b0; funct3 = 3'b010; addr = 32'h0; start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("mid_req", {31'h0, mem_req}, 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mid_busy", {31'h0, busy}, 32'h0);
      chk("rst_mid_done", {31'h0, done}, 32'h0);
      chk("rst_mid_rdata", rdata, 32'h0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      mem_rdata = 32'h12345678; start = 1'b1;
      @(negedge clk) start = 1'b0; mem_ready = 1'b1;
      @(negedge clk) mem_ready = 1'b0;
      chk("post_rst_lw", rdata, 32'h12345678);
      @(negedge clk);

      // start held during REQ and DONE must not spawn a second access
      we = 1'b0; funct3 = 3'b000; addr = 32'h2; mem_rdata = 32'h00AB0000; donec = 0;
      start = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done) donec++;
         start = (k < 2);
         mem_ready = (k == 1);
      end
      chk("one_done_per_start", donec, 1);
      chk("busy_ignored_rdata", rdata, 32'hFFFFFFAB);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
